// File: rtl/encoder_42_2_pkg.sv
// encoder_42_2_pkg: shared constants and index type for the 4-to-2 priority encoder
package encoder_42_2_pkg;
    localparam int ENC_N_IN  = 4;
    localparam int ENC_OUT_W = $clog2(ENC_N_IN);
    typedef logic [ENC_OUT_W-1:0] enc_idx_t;
endpackage

// File: rtl/encoder_42_2_comb.sv
// encoder_42_2_comb: combinational highest-set-bit index, any-set and multi-hot flags
module encoder_42_2_comb
    import encoder_42_2_pkg::*;
(
    input  logic [ENC_N_IN-1:0] a,
    output enc_idx_t            y_nxt,
    output logic                valid_nxt,
    output logic                multi_nxt
);
    // highest index wins; clearing the lowest set bit leaves something only when two or more are set
    always_comb begin
        y_nxt     = a[3] ? 2'd3 : a[2] ? 2'd2 : a[1] ? 2'd1 : 2'd0;
        valid_nxt = |a;
        multi_nxt = |(a & (a - 4'd1));
    end
endmodule

// File: rtl/encoder_42_2.sv
// encoder_42_2: registered 4-to-2 priority encoder with valid and multi-hot flags
module encoder_42_2
    import encoder_42_2_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    input  logic [ENC_N_IN-1:0] a,
    output enc_idx_t            y,
    output logic                valid,
    output logic                multi
);
    enc_idx_t y_nxt;
    logic     valid_nxt;
    logic     multi_nxt;

    encoder_42_2_comb u_comb (
        .a         (a),
        .y_nxt     (y_nxt),
        .valid_nxt (valid_nxt),
        .multi_nxt (multi_nxt)
    );

    // register the encoded result; reset clears all outputs and overrides sampling
    always_ff @(posedge clk) begin
        if (rst) begin
            y     <= '0;
            valid <= 1'b0;
            multi <= 1'b0;
        end else begin
            y     <= y_nxt;
            valid <= valid_nxt;
            multi <= multi_nxt;
        end
    end
endmodule

// File: tb/tb_encoder_42_2.sv
// tb_encoder_42_2: scoreboard bench for the registered 4-to-2 priority encoder
module tb_encoder_42_2;
    typedef struct packed {
        logic [1:0] y;
        logic       valid;
        logic       multi;
    } res_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] a   = 4'b0000;
    logic [1:0] y;
    logic       valid;
    logic       multi;
    res_t       sb[$];
    int         n_chk  = 0;
    int         n_pass = 0;

    encoder_42_2 dut (
        .clk   (clk),
        .rst   (rst),
        .a     (a),
        .y     (y),
        .valid (valid),
        .multi (multi)
    );

    always #5 clk = ~clk;

    function automatic res_t model(input logic [3:0] v);
        res_t r;
        int   cnt;
        r   = '0;
        cnt = 0;
        for (int i = 0; i < 4; i++) begin
            if (v[i]) begin
                r.y = 2'(i);
                cnt++;
            end
        end
        r.valid = (cnt > 0);
        r.multi = (cnt > 1);
        return r;
    endfunction

    task automatic check(input string tag, input logic [3:0] got, input logic [3:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic step(input string tag, input logic [3:0] av, input logic rv);
        res_t e;
        @(negedge clk);
        a   = av;
        rst = rv;
        sb.push_back(rv ? res_t'('0) : model(av));
        @(posedge clk);
        #1;
        if (sb.size() == 0) begin
            check({tag, " empty"}, 4'd1, 4'd0);
        end else begin
            e = sb.pop_front();
            check({tag, " y"},     {2'b00, y},     {2'b00, e.y});
            check({tag, " valid"}, {3'b000, valid}, {3'b000, e.valid});
            check({tag, " multi"}, {3'b000, multi}, {3'b000, e.multi});
        end
    endtask

    initial begin
        step("rst0", 4'b1111, 1'b1);
        step("rst1", 4'b1111, 1'b1);
        step("oh0", 4'b0001, 1'b0);
        step("oh1", 4'b0010, 1'b0);
        step("oh2", 4'b0100, 1'b0);
        step("oh3", 4'b1000, 1'b0);
        step("mh0011", 4'b0011, 1'b0);
        step("mh1111", 4'b1111, 1'b0);
        step("mh0001", 4'b0001, 1'b0);
        step("mh0101", 4'b0101, 1'b0);
        step("zero", 4'b0000, 1'b0);
        step("mid_pre", 4'b1000, 1'b0);
        step("mid_rst", 4'b1000, 1'b1);
        step("mid_post", 4'b1000, 1'b0);
        for (int v = 0; v < 16; v++) step($sformatf("ex%0d", v), 4'(v), 1'b0);
        for (int k = 0; k < 20; k++) step("rand", 4'($urandom_range(0, 15)), 1'b0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
